// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus, execute redirect and IF/ID handshake
// bundled for the fetch sequencer; master is the fetch side, slave the environment.
interface fetch_ctrl_if;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instruction_o;
  logic [63:0] PC_o;
  logic        flush_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, instruction_o, PC_o, flush_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, instruction_o, PC_o, flush_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fetches one instruction at a time over
// req/gnt/rvalid and hands it to the IF/ID register; redirects flush and drop stale data.
module fetch_ctrl #(
  parameter logic [63:0] ResetPC = 64'h0000_0000_0000_0000,
  parameter int          PcStep  = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_pc;
  logic [63:0] r_pc_out;
  logic [31:0] r_instr;
  logic        w_capture;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      FETCH: begin
        if (bus.imem_gnt_i) w_state_next = bus.redirect_i ? DROP : WAIT;
      end
      WAIT: begin
        if (bus.imem_rvalid_i) begin
          w_state_next = bus.redirect_i ? FETCH : HOLD;
          w_capture    = !bus.redirect_i;
        end else if (bus.redirect_i) begin
          w_state_next = DROP;
        end
      end
      HOLD: begin
        if (bus.redirect_i || bus.ready_i) w_state_next = FETCH;
      end
      DROP: begin
        // Stale response is swallowed here; the new target is already in r_pc.
        if (bus.imem_rvalid_i) w_state_next = FETCH;
      end
      default: w_state_next = FETCH;
    endcase
  end

  // Reset holds the FSM in FETCH, so the request/flush are masked while it is high.
  assign bus.imem_req_o    = (r_state == FETCH) && !reset_i;
  assign bus.imem_addr_o   = r_pc;
  assign bus.valid_o       = (r_state == HOLD) && !bus.redirect_i && !reset_i;
  assign bus.flush_o       = bus.redirect_i && !reset_i;
  assign bus.instruction_o = r_instr;
  assign bus.PC_o          = r_pc_out;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= FETCH;
      r_pc     <= ResetPC;
      r_pc_out <= 64'h0;
      r_instr  <= 32'h0000_0013;
    end else begin
      r_state <= w_state_next;
      if (bus.redirect_i) begin
        r_pc <= bus.redirect_pc_i & ~64'h3;
      end else if (w_capture) begin
        r_pc <= r_pc + 64'(PcStep);
      end
      if (w_capture) begin
        r_instr  <= bus.imem_rdata_i;
        r_pc_out <= r_pc;
      end
    end
  end

endmodule
